// File: rtl/cpu_defs.sv
// cpu_defs: arbiter state encoding, transfer size codes and the latched cache-port request.
package cpu_defs;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_t;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef struct packed {
    logic [31:0] a;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] st_data;
  } mem_req_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the bridge cache port between fetch and data, data first with bounded fetch starvation.
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] inst_a,
  input  logic        inst_access,
  input  logic [1:0]  inst_size,
  output logic        inst_ready,
  output logic [31:0] inst_data,
  input  logic [31:0] data_a,
  input  logic        data_access,
  input  logic        data_write,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_st_data,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);
  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  mem_req_t         req;
  logic             idle, below, pick_d, pick_i;
  always_comb begin
    idle   = state == ARB_IDLE;
    below  = cnt < CNT_W'(STARVE_LIMIT);
    pick_d = data_access & (~inst_access | below);
    pick_i = ~pick_d & inst_access;
  end
  // Grants last until mem_ready; returning through IDLE guarantees a low mem_access cycle.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else if (idle) begin
      state <= pick_d ? ARB_GNT_D : pick_i ? ARB_GNT_I : ARB_IDLE;
      cnt   <= (pick_i | ~inst_access) ? '0 : (pick_d & below) ? cnt + CNT_W'(1) : cnt;
    end else if (mem_ready || (state != ARB_GNT_I && state != ARB_GNT_D))
      state <= ARB_IDLE;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) req <= '0;
    else if (idle & pick_d) req <= {data_a, data_write, data_size, data_sel, data_st_data};
    else if (idle & pick_i) req <= {inst_a, 1'b0, inst_size, 4'b0000, 32'h0};
  always_comb begin
    mem_access  = state == ARB_GNT_I || state == ARB_GNT_D;
    mem_a       = req.a;
    mem_write   = req.write;
    mem_size    = req.size;
    mem_sel     = req.sel;
    mem_st_data = req.st_data;
    inst_ready  = mem_ready & (state == ARB_GNT_I);
    data_ready  = mem_ready & (state == ARB_GNT_D);
    inst_data   = mem_data;
    data_rdata  = mem_data;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks plus a grant-order scoreboard against a fixed-latency bridge model.
module tb_mem_port_arbiter;
  import cpu_defs::*;
  localparam int LAT = 3;
  logic        clk = 0, resetn = 0;
  logic [31:0] inst_a = 0, data_a = 0, data_st_data = 0, mem_data, inst_data, data_rdata;
  logic        inst_access = 0, data_access = 0, data_write = 0, mem_ready;
  logic [1:0]  inst_size = 0, data_size = 0, mem_size;
  logic [3:0]  data_sel = 0, mem_sel;
  logic        inst_ready, data_ready, mem_access, mem_write;
  logic [31:0] mem_a, mem_st_data;
  typedef struct {
    bit          is_d;
    logic [31:0] a;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] st;
  } txn_t;
  txn_t exp_q[$];
  txn_t cur;
  int errors = 0, checks = 0, n_i = 0, n_d = 0, stray_req = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_a(inst_a), .inst_access(inst_access), .inst_size(inst_size),
    .inst_ready(inst_ready), .inst_data(inst_data),
    .data_a(data_a), .data_access(data_access), .data_write(data_write),
    .data_size(data_size), .data_sel(data_sel), .data_st_data(data_st_data),
    .data_ready(data_ready), .data_rdata(data_rdata),
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
    .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data)
  );
  function automatic logic [31:0] rdata(input logic [31:0] a);
    return (a == 32'hBFC00000) ? 32'h3C1D0001 : ~a;
  endfunction
  // Bridge: completes LAT cycles after mem_access is first seen; stray pulses arrive while idle.
  initial begin
    int w, stray_done;
    w = 0; stray_done = 0; mem_ready = 0; mem_data = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 0;
      if (stray_req != stray_done) begin
        stray_done = stray_req; mem_ready = 1; mem_data = 32'hFFFF0000;
      end else if (resetn && mem_access) begin
        if (w == LAT) begin mem_ready = 1; mem_data = rdata(mem_a); w = 0; end
        else w++;
      end else w = 0;
    end
  end
  // Scoreboard: each new grant pops the next expected transaction; fields and ready steering follow it.
  initial begin
    logic prev, exp_ir, exp_dr;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!resetn) prev = 0;
      else begin
        if (mem_access && !prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL grant_unexpected: got grant mem_a=%h, expected no grant", mem_a);
          end else cur = exp_q.pop_front();
        end
        if (mem_access) begin
          checks++;
          if ({mem_a, mem_write, mem_size, mem_sel, mem_st_data} !== {cur.a, cur.wr, cur.size, cur.sel, cur.st}) begin
            errors++;
            $display("FAIL grant_fields: got a=%h w=%b sz=%b sel=%b st=%h, expected a=%h w=%b sz=%b sel=%b st=%h",
                     mem_a, mem_write, mem_size, mem_sel, mem_st_data, cur.a, cur.wr, cur.size, cur.sel, cur.st);
          end
        end
        exp_ir = mem_ready && mem_access && !cur.is_d;
        exp_dr = mem_ready && mem_access && cur.is_d;
        checks++;
        if ({inst_ready, data_ready} !== {exp_ir, exp_dr}) begin
          errors++; $display("FAIL ready_steer: got i/d=%b%b, expected %b%b", inst_ready, data_ready, exp_ir, exp_dr);
        end
        if (inst_ready) begin
          n_i++; checks++;
          if (inst_data !== rdata(cur.a)) begin
            errors++; $display("FAIL inst_data: got %h, expected %h", inst_data, rdata(cur.a));
          end
        end
        if (data_ready) begin
          n_d++; checks++;
          if (data_rdata !== rdata(cur.a)) begin
            errors++; $display("FAIL data_rdata: got %h, expected %h", data_rdata, rdata(cur.a));
          end
        end
        prev = mem_access;
      end
    end
  end
  task test_reset;
    resetn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_access, inst_ready, data_ready, mem_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got acc/ir/dr/wr=%b%b%b%b, expected 0000", mem_access, inst_ready, data_ready, mem_write);
    end
    checks++;
    if ({mem_a, mem_size, mem_sel, mem_st_data} !== 70'h0) begin
      errors++; $display("FAIL reset_fields: got a=%h sel=%b st=%h, expected zero", mem_a, mem_sel, mem_st_data);
    end
    resetn = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_access, inst_ready, data_ready} !== 3'b000) begin
      errors++; $display("FAIL idle_no_req: got acc/ir/dr=%b%b%b, expected 000", mem_access, inst_ready, data_ready);
    end
  endtask
  task test_single_fetch;
    int cyc;
    @(posedge clk); #1;
    inst_a = 32'hBFC00000; inst_size = SIZE_W; inst_access = 1;
    exp_q.push_back('{1'b0, 32'hBFC00000, 1'b0, SIZE_W, 4'b0000, 32'h0});
    @(negedge clk);
    checks++;
    if (mem_access !== 1'b0) begin errors++; $display("FAIL fetch_not_early: got mem_access=%b, expected 0", mem_access); end
    @(negedge clk);
    checks++;
    if ({mem_access, mem_write, mem_a} !== {2'b10, 32'hBFC00000}) begin
      errors++; $display("FAIL fetch_grant: got acc=%b wr=%b a=%h, expected 1 0 bfc00000", mem_access, mem_write, mem_a);
    end
    cyc = 0;
    while (!inst_ready && cyc < 20) begin
      checks++;
      if (data_ready !== 1'b0) begin errors++; $display("FAIL fetch_no_dready: got %b, expected 0", data_ready); end
      @(negedge clk); cyc++;
    end
    checks++;
    if ({inst_ready, data_ready} !== 2'b10 || cyc != LAT) begin
      errors++; $display("FAIL fetch_ready: got ir=%b dr=%b after %0d cycles, expected 1 0 after %0d", inst_ready, data_ready, cyc, LAT);
    end
    checks++;
    if (inst_data !== 32'h3C1D0001) begin errors++; $display("FAIL fetch_data: got %h, expected 3c1d0001", inst_data); end
    @(posedge clk); #1 inst_access = 0;
    @(negedge clk);
    checks++;
    if ({inst_ready, mem_access} !== 2'b00) begin
      errors++; $display("FAIL fetch_one_pulse: got ir=%b acc=%b, expected 0 0", inst_ready, mem_access);
    end
  endtask
  task test_simultaneous;
    int cyc;
    @(posedge clk); #1;
    inst_a = 32'h00001000; inst_size = SIZE_W;
    data_a = 32'h80000200; data_write = 0; data_size = SIZE_W; data_sel = 4'hF; data_st_data = 32'h12345678;
    inst_access = 1; data_access = 1;
    exp_q.push_back('{1'b1, 32'h80000200, 1'b0, SIZE_W, 4'hF, 32'h12345678});
    exp_q.push_back('{1'b0, 32'h00001000, 1'b0, SIZE_W, 4'h0, 32'h0});
    @(negedge clk); @(negedge clk);
    checks++;
    if ({mem_access, mem_a} !== {1'b1, 32'h80000200}) begin
      errors++; $display("FAIL simul_data_first: got acc=%b a=%h, expected 1 80000200", mem_access, mem_a);
    end
    cyc = 0;
    while (!data_ready && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL simul_data_done: got %b, expected 1", data_ready); end
    @(posedge clk); #1 data_access = 0;
    @(negedge clk);
    checks++;
    if (mem_access !== 1'b0) begin errors++; $display("FAIL simul_idle_gap: got mem_access=%b, expected 0", mem_access); end
    @(negedge clk);
    checks++;
    if ({mem_access, mem_a} !== {1'b1, 32'h00001000}) begin
      errors++; $display("FAIL simul_inst_next: got acc=%b a=%h, expected 1 00001000", mem_access, mem_a);
    end
    cyc = 0;
    while (!inst_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(posedge clk); #1 inst_access = 0;
    @(negedge clk);
  endtask
  task test_starvation;
    int cyc, i0, d0;
    i0 = n_i; d0 = n_d;
    @(posedge clk); #1;
    inst_a = 32'h00002000; data_a = 32'h80000300; data_sel = 4'hF; data_st_data = 32'h0; data_write = 0;
    inst_access = 1; data_access = 1;
    repeat (4) exp_q.push_back('{1'b1, 32'h80000300, 1'b0, SIZE_W, 4'hF, 32'h0});
    exp_q.push_back('{1'b0, 32'h00002000, 1'b0, SIZE_W, 4'h0, 32'h0});
    exp_q.push_back('{1'b1, 32'h80000300, 1'b0, SIZE_W, 4'hF, 32'h0});
    cyc = 0;
    while (!inst_ready && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (inst_ready !== 1'b1 || n_d - d0 != 4) begin
      errors++; $display("FAIL starve_inst_turn: got ir=%b after %0d data grants, expected 1 after 4", inst_ready, n_d - d0);
    end
    @(posedge clk); #1 inst_access = 0;
    cyc = 0;
    while (!data_ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk); #1 data_access = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (n_d - d0 != 5 || n_i - i0 != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL starve_totals: got d=%0d i=%0d left=%0d, expected 5 1 0", n_d - d0, n_i - i0, exp_q.size());
    end
  endtask
  task test_store;
    int pulses;
    @(posedge clk); #1;
    data_write = 1; data_a = 32'h80001004; data_size = SIZE_H; data_sel = 4'b0011; data_st_data = 32'hDEADBEEF;
    data_access = 1;
    exp_q.push_back('{1'b1, 32'h80001004, 1'b1, SIZE_H, 4'b0011, 32'hDEADBEEF});
    @(negedge clk); @(negedge clk);
    checks++;
    if ({mem_access, mem_write, mem_sel, mem_st_data} !== {2'b11, 4'b0011, 32'hDEADBEEF}) begin
      errors++; $display("FAIL store_grant: got acc=%b wr=%b sel=%b st=%h, expected 1 1 0011 deadbeef", mem_access, mem_write, mem_sel, mem_st_data);
    end
    @(posedge clk); #1;
    data_a = 32'h0; data_st_data = 32'h0; data_sel = 4'hF; data_write = 0; data_size = SIZE_B;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (data_ready) begin
        pulses++;
        @(posedge clk); #1 data_access = 0;
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL store_pulses: got %0d, expected 1", pulses); end
  endtask
  task test_stray_and_drop;
    int cyc;
    stray_req++;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({mem_ready, inst_ready, data_ready, mem_access} !== 4'b1000) begin
      errors++; $display("FAIL stray_ignored: got mr/ir/dr/acc=%b%b%b%b, expected 1000", mem_ready, inst_ready, data_ready, mem_access);
    end
    @(posedge clk); #1;
    inst_a = 32'h00003000; inst_size = SIZE_B; inst_access = 1;
    exp_q.push_back('{1'b0, 32'h00003000, 1'b0, SIZE_B, 4'h0, 32'h0});
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 inst_access = 0;
    cyc = 0;
    while (!inst_ready && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (inst_ready !== 1'b1) begin errors++; $display("FAIL drop_still_completes: got ir=%b, expected 1", inst_ready); end
    @(negedge clk);
  endtask
  task test_async_reset;
    @(posedge clk); #1;
    data_a = 32'h80000400; data_write = 0; data_size = SIZE_W; data_sel = 4'hF; data_st_data = 32'h0;
    data_access = 1;
    exp_q.push_back('{1'b1, 32'h80000400, 1'b0, SIZE_W, 4'hF, 32'h0});
    @(negedge clk); @(negedge clk);
    checks++;
    if (mem_access !== 1'b1) begin errors++; $display("FAIL arst_granted: got mem_access=%b, expected 1", mem_access); end
    @(posedge clk); #2 resetn = 0;
    #1;
    checks++;
    if ({mem_access, mem_write, data_ready, mem_a} !== 35'h0) begin
      errors++; $display("FAIL arst_immediate: got acc=%b wr=%b dr=%b a=%h, expected all 0", mem_access, mem_write, data_ready, mem_a);
    end
    data_access = 0;
    @(negedge clk); resetn = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_access, inst_ready, data_ready} !== 3'b000) begin
        errors++; $display("FAIL arst_idle: got acc/ir/dr=%b%b%b, expected 000", mem_access, inst_ready, data_ready);
      end
    end
  endtask
  initial begin
    test_reset;
    test_single_fetch;
    test_simultaneous;
    test_starvation;
    test_store;
    test_stray_and_drop;
    test_async_reset;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending grants, expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
